video_timing: RTL and testbench

- Raster timing generator sitting directly upstream of the tile/palette pixel pipeline.
- Produces the pixel coordinates that feed the pipeline's tile-address and ROM-address logic.
- Produces hsync, vsync and display-enable, delayed by a fixed number of pixel slots so they line up with the pipeline's registered colour output.
- Default timing is 640x480@60 (800x525 total) with a pixel-clock enable.

---
 rtl/video_timing.sv | 77 +++++++
 tb/tb_video_timing.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/video_timing.sv
// video_timing: raster counters, coordinate decode and pipeline-aligned sync/de generation
module video_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 3,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pix_en,
    output logic [9:0] o_pixel_x,
    output logic [8:0] o_pixel_y,
    output logic       o_active,
    output logic       o_line_start,
    output logic       o_frame_start,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_de
);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    logic [9:0] r_h_cnt, r_v_cnt;
    logic       r_line_start, r_frame_start;
    logic       w_h_wrap, w_v_wrap, w_hs_raw, w_vs_raw;
    logic [2:0] w_raw;
    assign w_h_wrap      = r_h_cnt == H_LAST;
    assign w_v_wrap      = r_v_cnt == V_LAST;
    assign o_active      = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign o_pixel_x     = (r_h_cnt < H_ACT) ? r_h_cnt : '0;
    assign o_pixel_y     = (r_v_cnt < V_ACT) ? r_v_cnt[8:0] : '0;
    assign w_hs_raw      = (r_h_cnt >= HS_BEG && r_h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
    assign w_vs_raw      = (r_v_cnt >= VS_BEG && r_v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
    assign w_raw         = {w_hs_raw, w_vs_raw, o_active};
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= i_pix_en && w_h_wrap;
            r_frame_start <= i_pix_en && w_h_wrap && w_v_wrap;
            if (i_pix_en) begin
                r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 10'd1;
                if (w_h_wrap) r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 10'd1;
            end
        end
    end
    if (PIPE_DELAY == 0) begin : g_nodly
        assign {o_hsync, o_vsync, o_de} = w_raw;
    end else begin : g_dly
        logic [2:0] r_dly [PIPE_DELAY];
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int i = 0; i < PIPE_DELAY; i++) r_dly[i] <= {~SYNC_POL, ~SYNC_POL, 1'b0};
            end else if (i_pix_en) begin
                r_dly[0] <= w_raw;
                for (int i = 1; i < PIPE_DELAY; i++) r_dly[i] <= r_dly[i-1];
            end
        end
        assign {o_hsync, o_vsync, o_de} = r_dly[PIPE_DELAY-1];
    end
endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing: directed checks of default, zero-delay and reduced-size timing builds
module tb_video_timing;
    logic clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0;
    always #5 clk = ~clk;
    logic [9:0] a_x, z_x, s_x;
    logic [8:0] a_y, z_y, s_y;
    logic a_act, a_ls, a_fs, a_hs, a_vs, a_de;
    logic z_act, z_ls, z_fs, z_hs, z_vs, z_de;
    logic s_act, s_ls, s_fs, s_hs, s_vs, s_de;
    int errors = 0, checks = 0;
    int mh, mv, sh, sv, mn;

    video_timing dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .o_pixel_x(a_x), .o_pixel_y(a_y), .o_active(a_act), .o_line_start(a_ls),
        .o_frame_start(a_fs), .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de)
    );
    video_timing #(.PIPE_DELAY(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .o_pixel_x(z_x), .o_pixel_y(z_y), .o_active(z_act), .o_line_start(z_ls),
        .o_frame_start(z_fs), .o_hsync(z_hs), .o_vsync(z_vs), .o_de(z_de)
    );
    video_timing #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)) dus (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .o_pixel_x(s_x), .o_pixel_y(s_y), .o_active(s_act), .o_line_start(s_ls),
        .o_frame_start(s_fs), .o_hsync(s_hs), .o_vsync(s_vs), .o_de(s_de)
    );

    function automatic logic [2:0] dly(input int h, input int v, input int n, input int ht, input int vt,
                                       input int ha, input int hss, input int hse,
                                       input int va, input int vss, input int vse);
        int p, ph, pv;
        if (n < 3) return 3'b000;
        p  = (v * ht + h - 3 + ht * vt) % (ht * vt);
        ph = p % ht;
        pv = p / ht;
        return {ph >= hss && ph < hse, pv >= vss && pv < vse, ph < ha && pv < va};
    endfunction

    task automatic tick(input logic en);
        pix_en = en;
        @(posedge clk);
        if (en && rst_n) begin
            if (mh == 799) begin mh = 0; mv = (mv == 524) ? 0 : mv + 1; end else mh++;
            if (sh == 14) begin sh = 0; sv = (sv == 9) ? 0 : sv + 1; end else sh++;
            mn++;
        end
        #1;
    endtask

    task automatic clear_model;
        mh = 0; mv = 0; sh = 0; sv = 0; mn = 0;
    endtask

    task automatic test_reset;
        int fs = 0;
        rst_n = 1'b0;
        pix_en = 1'b1;
        clear_model();
        repeat (5) @(posedge clk);
        #1;
        checks++; if (a_x !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d expected 0", a_x); end
        checks++; if (a_y !== 9'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", a_y); end
        checks++; if (a_act !== 1'b1) begin errors++; $display("FAIL reset_active: got %b expected 1", a_act); end
        checks++; if (a_de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b expected 0", a_de); end
        checks++; if ({a_hs, a_vs} !== 2'b11) begin errors++; $display("FAIL reset_sync: got %b expected 11", {a_hs, a_vs}); end
        checks++; if ({a_ls, a_fs} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {a_ls, a_fs}); end
        checks++; if ({s_hs, s_vs, s_de} !== 3'b000) begin errors++; $display("FAIL reset_small_sync: got %b expected 000", {s_hs, s_vs, s_de}); end
        checks++; if ({z_hs, z_vs, z_de} !== 3'b111) begin errors++; $display("FAIL reset_nodly: got %b expected 111", {z_hs, z_vs, z_de}); end
        rst_n = 1'b1;
        tick(1); if (a_fs) fs++;
        tick(1); if (a_fs) fs++;
        checks++; if (a_de !== 1'b0) begin errors++; $display("FAIL reset_de_slot2: got %b expected 0", a_de); end
        tick(1); if (a_fs) fs++;
        checks++; if (a_de !== 1'b1) begin errors++; $display("FAIL reset_de_slot3: got %b expected 1", a_de); end
        checks++; if (a_x !== 10'd3) begin errors++; $display("FAIL reset_x_slot3: got %0d expected 3", a_x); end
        checks++; if (fs != 0) begin errors++; $display("FAIL reset_no_frame_start: got %0d expected 0", fs); end
    endtask

    task automatic test_horizontal;
        int hs_low = 0, hs_first = -1, z_first = -1, de_cnt = 0, run = 0, de_run = 0;
        int x_err = 0, z_err = 0, m_err = 0, ls = 0;
        for (int i = 0; i < 800 && mh != 0; i++) tick(1);
        for (int i = 0; i < 800; i++) begin
            tick(1);
            if (a_hs === 1'b0) begin hs_low++; if (hs_first < 0) hs_first = mh; end
            if (z_hs === 1'b0 && z_first < 0) z_first = mh;
            if (a_de === 1'b1) begin de_cnt++; run++; if (run > de_run) de_run = run; end else run = 0;
            if (int'(a_x) !== ((mh < 640) ? mh : 0)) x_err++;
            if (z_de !== z_act) z_err++;
            if ({a_hs, a_vs, a_de} !== (dly(mh, mv, mn, 800, 525, 640, 656, 752, 480, 490, 492) ^ 3'b110)) m_err++;
            if (a_ls) ls++;
        end
        checks++; if (hs_low != 96) begin errors++; $display("FAIL horiz_hs_width: got %0d expected 96", hs_low); end
        checks++; if (hs_first != 659) begin errors++; $display("FAIL horiz_hs_first: got %0d expected 659", hs_first); end
        checks++; if (de_cnt != 640) begin errors++; $display("FAIL horiz_de_count: got %0d expected 640", de_cnt); end
        checks++; if (de_run != 640) begin errors++; $display("FAIL horiz_de_run: got %0d expected 640", de_run); end
        checks++; if (x_err != 0) begin errors++; $display("FAIL horiz_pixel_x: got %0d bad cycles expected 0", x_err); end
        checks++; if (z_first != 656) begin errors++; $display("FAIL nodly_hs_first: got %0d expected 656", z_first); end
        checks++; if (z_err != 0) begin errors++; $display("FAIL nodly_de_eq_active: got %0d bad cycles expected 0", z_err); end
        checks++; if (m_err != 0) begin errors++; $display("FAIL horiz_model: got %0d bad cycles expected 0", m_err); end
        checks++; if (ls != 1) begin errors++; $display("FAIL horiz_line_start: got %0d expected 1", ls); end
    endtask

    task automatic test_enable;
        int prev = -1, period = 0, wide = 0, m_err = 0, al_err = 0, ls_n = 0;
        logic last = 1'b0;
        for (int i = 0; i < 3202; i++) begin
            tick((i % 2) == 0);
            if (a_ls) begin if (prev >= 0) period = i - prev; prev = i; ls_n++; end
            if (a_ls && last) wide++;
            last = a_ls;
            if ({a_hs, a_vs, a_de} !== (dly(mh, mv, mn, 800, 525, 640, 656, 752, 480, 490, 492) ^ 3'b110)) m_err++;
            if (int'(a_x) !== ((mh < 640) ? mh : 0)) m_err++;
            if (mh == 3 && a_de !== 1'b1) al_err++;
            if (mh == 2 && a_de !== 1'b0) al_err++;
        end
        checks++; if (period != 1600) begin errors++; $display("FAIL enable_line_period: got %0d expected 1600", period); end
        checks++; if (ls_n != 2) begin errors++; $display("FAIL enable_line_count: got %0d expected 2", ls_n); end
        checks++; if (wide != 0) begin errors++; $display("FAIL enable_pulse_width: got %0d wide pulses expected 0", wide); end
        checks++; if (m_err != 0) begin errors++; $display("FAIL enable_model: got %0d bad cycles expected 0", m_err); end
        checks++; if (al_err != 0) begin errors++; $display("FAIL enable_de_align: got %0d bad cycles expected 0", al_err); end
    endtask

    task automatic test_frame;
        int ls = 0, fs = 0, fs_alone = 0, fs_pos = 0, vs_hi = 0, ymax = 0, y_err = 0, m_err = 0;
        for (int i = 0; i < 150; i++) begin
            tick(1);
            if (s_ls) ls++;
            if (s_fs) begin fs++; if (!s_ls) fs_alone++; if (sh != 0 || sv != 0) fs_pos++; end
            if (s_vs === 1'b1) vs_hi++;
            if (int'(s_y) > ymax) ymax = int'(s_y);
            if (int'(s_y) !== ((sv < 6) ? sv : 0)) y_err++;
            if ({s_hs, s_vs, s_de} !== dly(sh, sv, mn, 15, 10, 8, 10, 13, 6, 7, 9)) m_err++;
        end
        checks++; if (ls != 10) begin errors++; $display("FAIL frame_line_starts: got %0d expected 10", ls); end
        checks++; if (fs != 1) begin errors++; $display("FAIL frame_frame_starts: got %0d expected 1", fs); end
        checks++; if (fs_alone != 0) begin errors++; $display("FAIL frame_fs_without_ls: got %0d expected 0", fs_alone); end
        checks++; if (fs_pos != 0) begin errors++; $display("FAIL frame_fs_position: got %0d expected 0", fs_pos); end
        checks++; if (vs_hi != 30) begin errors++; $display("FAIL frame_vsync_width: got %0d expected 30", vs_hi); end
        checks++; if (ymax != 5) begin errors++; $display("FAIL frame_y_max: got %0d expected 5", ymax); end
        checks++; if (y_err != 0) begin errors++; $display("FAIL frame_pixel_y: got %0d bad cycles expected 0", y_err); end
        checks++; if (m_err != 0) begin errors++; $display("FAIL frame_model: got %0d bad cycles expected 0", m_err); end
    endtask

    task automatic test_mid_reset;
        int fs = 0, m_err = 0;
        for (int i = 0; i < 200 && !(sh == 5 && sv == 3); i++) tick(1);
        rst_n = 1'b0;
        #1;
        checks++; if ({s_x, s_y} !== 19'd0) begin errors++; $display("FAIL midrst_xy: got x=%0d y=%0d expected 0 0", s_x, s_y); end
        checks++; if ({s_hs, s_vs, s_de} !== 3'b000) begin errors++; $display("FAIL midrst_small_sync: got %b expected 000", {s_hs, s_vs, s_de}); end
        checks++; if (s_act !== 1'b1) begin errors++; $display("FAIL midrst_active: got %b expected 1", s_act); end
        checks++; if ({a_hs, a_vs, a_de} !== 3'b110) begin errors++; $display("FAIL midrst_sync: got %b expected 110", {a_hs, a_vs, a_de}); end
        clear_model();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 150; i++) begin
            tick(1);
            if (i == 1) begin
                checks++; if (s_x !== 10'd1) begin errors++; $display("FAIL midrst_first_x: got %0d expected 1", s_x); end
            end
            if (i < 150 && s_fs) fs++;
            if ({s_hs, s_vs, s_de} !== dly(sh, sv, mn, 15, 10, 8, 10, 13, 6, 7, 9)) m_err++;
        end
        checks++; if (fs != 0) begin errors++; $display("FAIL midrst_early_fs: got %0d expected 0", fs); end
        checks++; if (s_fs !== 1'b1) begin errors++; $display("FAIL midrst_wrap_fs: got %b expected 1", s_fs); end
        checks++; if (m_err != 0) begin errors++; $display("FAIL midrst_model: got %0d bad cycles expected 0", m_err); end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_enable();
        test_frame();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
